// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulator slice.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;
  localparam int COUNT_DEF  = 4;

endpackage

// File: rtl/mac_accumulator_sat_add.sv
// Signed ACC_W adder with overflow flag; clamps instead of wrapping
// when MAC_ACCUMULATOR_SATURATE_EN is defined.
module sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  // clamp direction follows the common operand sign
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}}
                   : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums COUNT signed products and hands the result out on valid/ready.
// Build option: MAC_ACCUMULATOR_SATURATE_EN selects saturating adds.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int COUNT  = COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic signed [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         add_sum;
  logic                     add_ovf;
  logic                     accept;
  logic                     last;

  assign prod_s   = product;
  assign prod_ext = ACC_W'(prod_s);

  sat_add #(
    .W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready  = (state_q == ACCUM) && !clear;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CNT_W'(COUNT - 1));
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          ovf_d = ovf_q | add_ovf;
          if (last) begin
            result_d = add_sum;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = HOLD;
          end else begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: default-width instance plus an ACC_W=8 instance.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] product = '0;
  logic       clear = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [11:0] result;
  logic       overflow;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_product = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [7:0] b_result;
  logic       b_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  int q_res[$];
  int q_ov[$];

  logic signed [11:0] m_sum;
  int  m_cnt;
  bit  m_ov;
  bit  m_hold;

  always #5 clk = ~clk;

  mac_accumulator #(
    .PROD_W (8),
    .ACC_W  (12),
    .COUNT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  mac_accumulator #(
    .PROD_W (8),
    .ACC_W  (8),
    .COUNT  (4)
  ) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .product   (b_product),
    .clear     (1'b0),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .result    (b_result),
    .overflow  (b_overflow)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_sum  = '0;
    m_cnt  = 0;
    m_ov   = 1'b0;
    m_hold = 1'b0;
  endfunction

  function automatic void m_add(input int p);
    logic signed [11:0] a, b, s;
    bit ov;
    a  = m_sum;
    b  = 12'(p);
    s  = a + b;
    ov = (a[11] == b[11]) && (s[11] != a[11]);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    if (ov) s = a[11] ? -12'sd2048 : 12'sd2047;
`endif
    m_sum = s;
    m_ov  = m_ov | ov;
  endfunction

  // one clock of stimulus on the default instance, checked mid-cycle
  task automatic cyc(input bit iv, input int p,
                     input bit clr, input bit ordy);
    @(negedge clk);
    in_valid  = iv;
    product   = 8'(p);
    clear     = clr;
    out_ready = ordy;
    #1;
    chk("in_ready", int'(in_ready), int'(!m_hold && !clr));
    chk("out_valid", int'(out_valid), int'(m_hold));
    if (m_hold && q_res.size() > 0) begin
      chk("hold_result", int'($signed(result)), q_res[0]);
      chk("hold_ovf", int'(overflow), q_ov[0]);
    end
    if (m_hold) begin
      if (ordy) begin
        if (q_res.size() > 0) begin
          void'(q_res.pop_front());
          void'(q_ov.pop_front());
        end else begin
          chk("sb_empty", 1, 0);
        end
        m_hold = 1'b0;
        m_ov   = 1'b0;
      end
    end else if (clr) begin
      m_sum = '0;
      m_cnt = 0;
      m_ov  = 1'b0;
    end else if (iv) begin
      m_add(int'($signed(8'(p))));
      if (m_cnt == 3) begin
        q_res.push_back(int'(m_sum));
        q_ov.push_back(int'(m_ov));
        m_sum  = '0;
        m_cnt  = 0;
        m_hold = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic feed4(input int a, input int b,
                       input int c, input int d, input bit ordy);
    cyc(1'b1, a, 1'b0, ordy);
    cyc(1'b1, b, 1'b0, ordy);
    cyc(1'b1, c, 1'b0, ordy);
    cyc(1'b1, d, 1'b0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_overflow", int'(overflow), 0);
    m_reset();
    q_res.delete();
    q_ov.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    m_reset();
    #12;
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_result", int'(result), 0);
    chk("por_overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("por_in_ready", int'(in_ready), 1);

    // back-to-back with immediate drain
    feed4(49, -56, 7, 12, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // clear discards a partial sum
    cyc(1'b1, 10, 1'b0, 1'b1);
    cyc(1'b1, 20, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b1);
    feed4(1, 2, 3, 4, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // stall in HOLD with input pending
    feed4(1, 2, 3, 4, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 99, 1'b0, 1'b0);
    cyc(1'b1, 99, 1'b0, 1'b1);
    feed4(5, 6, 7, 8, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // negative sums
    feed4(-100, -100, -100, -100, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    feed4(-128, 127, -128, 127, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // clear beats in_valid mid-sum
    cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b1, 50, 1'b1, 1'b0);
    feed4(1, 1, 1, 1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // async reset after two products, then in HOLD
    cyc(1'b1, 30, 1'b0, 1'b0);
    cyc(1'b1, 40, 1'b0, 1'b0);
    do_reset();
    feed4(1, 1, 1, 1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    do_reset();
    feed4(1, 1, 1, 1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("sb_drain", q_res.size(), 0);

    // narrow accumulator overflow
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_product  = (i < 2) ? 8'd64 : 8'd0;
      #1;
      chk("n_in_ready", int'(b_in_ready), 1);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    begin
      int waited;
      waited = 0;
      #1;
      while (!b_out_valid && waited < 8) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("n_out_valid", int'(b_out_valid), 1);
    end
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    chk("n_result", int'($signed(b_result)), 127);
`else
    chk("n_result", int'($signed(b_result)), -128);
`endif
    chk("n_overflow", int'(b_overflow), 1);
    chk("n_in_ready_hold", int'(b_in_ready), 0);
    @(negedge clk);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    #1;
    chk("n_drop_valid", int'(b_out_valid), 0);
    chk("n_ovf_clear", int'(b_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Downstream consumer of the 4x4 signed Booth multiplier's 8-bit signed product. It sums COUNT consecutive products into a wider signed accumulator to form a dot-product term. It presents the sum through a valid/ready output handshake. Upstream side uses valid/ready so a multiplier wrapper can stall on it.

Parameters:
PROD_W, 8, width of signed input product
ACC_W, 12, width of signed accumulator/result; must be >= PROD_W
COUNT, 4, number of products summed per result; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  product is valid this cycle
in_ready  output  1  block accepts product this cycle
product  input  PROD_W  signed product from multiplier
clear  input  1  synchronous discard of partial sum
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts result
result  output  ACC_W  signed accumulated sum
overflow  output  1  sticky; set if any add in the current result overflowed ACC_W

Behaviour:
- Reset (async, any time, including mid-accumulation or mid-HOLD): state=ACCUM, acc=0, cnt=0, result=0, out_valid=0, overflow=0. in_ready is 1 once rst deasserts.
- States:
  - ACCUM: in_ready = !clear.
  - HOLD: in_ready = 0, out_valid = 1.
- ACCUM, accept = in_valid && in_ready:
  - acc <= acc + sign_extend(product)
  - cnt <= cnt+1
  - overflow |= signed overflow of that add
- Last accept (cnt==COUNT-1):
  - result <= final sum (including this product)
  - state -> HOLD; out_valid=1 next cycle. Latency is 1 cycle from last accept.
  - acc <= 0, cnt <= 0
- HOLD:
  - result and overflow are stable.
  - On out_ready, out_valid drops next cycle, overflow clears, state -> ACCUM.
  - No input is accepted in the same cycle as out_ready (no bypass).
- clear in ACCUM: acc <= 0, cnt <= 0, overflow <= 0. The product presented that cycle is not accepted (in_ready=0); clear wins over in_valid.
- clear in HOLD: ignored.
- Arithmetic: two's complement, ACC_W bits, wrap-around on overflow (default build).
  - Overflow is detected when both operands have the same sign and the sum's sign differs.
- COUNT==1: every accepted product goes directly to HOLD.
- in_valid while in HOLD: product not consumed; upstream must hold it.

Optional Feature:
MAC_ACCUMULATOR_SATURATE_EN
- Defined: on overflow, acc clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) according to the operand sign. Overflow is still flagged. Subsequent adds continue from the clamped value.
- Undefined: wrap-around as specified in Behaviour.

Decomposition:
- Package mac_pkg: state enum {ACCUM, HOLD}; default width constants PROD_W_DEF=8, ACC_W_DEF=12, COUNT_DEF=4.
- One sub-module sat_add:
  - Combinational signed ACC_W adder with overflow output.
  - Saturating clamp when MAC_ACCUMULATOR_SATURATE_EN is defined.
  - Keeps the FSM/counter logic in mac_accumulator separate from the arithmetic.

Test Plan:
- Default params; feed 49, -56, 7, 12 back-to-back with out_ready=1 -> out_valid 1 cycle after 4th accept, result=12, overflow=0; in_ready=0 during HOLD.
- Feed 10, 20; assert clear; feed 1, 2, 3, 4 -> result=10; the first two products are discarded.
- Hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> result stable, no product consumed; raise out_ready -> next 4 products form a new sum.
- ACC_W=8 instance, feed 64, 64, 0, 0 -> wrap build: result=-128, overflow=1; MAC_ACCUMULATOR_SATURATE_EN build: result=127, overflow=1.
- Assert rst after 2 accepted products and during HOLD -> all outputs 0 immediately (async); a subsequent full sequence of 1, 1, 1, 1 -> result=4.
- Assert clear and in_valid in the same cycle -> in_ready=0, product not counted; cnt=0 verified by the next result summing exactly 4 later products.
